time_cnt: RTL



---
 rtl/time_cnt.sv | 181 ++++++++++++++++++
 1 files changed

// File: rtl/time_cnt.sv
// time_cnt: 24-hour time-of-day counter (HH:MM:SS) for the display path.
//
// A prescaler divides CLK down to a one-second tick that advances six BCD
// digits. Set pulses adjust seconds, minutes and hours. Every digit is
// decoded into an active-high 7-segment pattern, and hours and seconds are
// also presented in binary for the LED bars. All outputs are registered.
//
// Ports:
//   CLK      system clock, rising edge
//   RST      asynchronous, active-high reset
//   sec_clr  pulse: seconds and prescaler to zero (wins over a tick)
//   min_up   pulse: minute +1, never carries into hours
//   hour_up  pulse: hour +1, adds on top of any minute carry
//   hour_hi .. sec_lo  7-segment patterns {g,f,e,d,c,b,a}
//   hour_bin hour 0..23 in binary
//   sec_bin  second 0..59 in binary
//   tick     one-cycle pulse aligned with the capture of new digits
module time_cnt #(
  parameter int CLK_HZ = 50_000_000
) (
  input  logic       CLK,
  input  logic       RST,
  input  logic       sec_clr,
  input  logic       min_up,
  input  logic       hour_up,
  output logic [6:0] hour_hi,
  output logic [6:0] hour_lo,
  output logic [6:0] min_hi,
  output logic [6:0] min_lo,
  output logic [6:0] sec_hi,
  output logic [6:0] sec_lo,
  output logic [4:0] hour_bin,
  output logic [5:0] sec_bin,
  output logic       tick
);

  localparam int              PW        = $clog2(CLK_HZ);
  localparam logic [PW-1:0]   PCNT_MAX  = PW'(CLK_HZ - 1);
  localparam logic [6:0]      SEG_ZERO  = 7'b0111111;

  // Each pair holds {tens, units} in BCD.
  logic [PW-1:0] pcnt_r;
  logic [7:0]    sec_r;
  logic [7:0]    min_r;
  logic [7:0]    hour_r;

  logic [PW-1:0] pcnt_next_s;
  logic [7:0]    sec_next_s;
  logic [7:0]    min_step_s;
  logic [7:0]    min_next_s;
  logic [7:0]    hour_step_s;
  logic [7:0]    hour_next_s;
  logic          tick_s;
  logic          sec_carry_s;
  logic          hour_carry_s;

  // BCD pair increment that wraps to 00 after the given last value.
  function automatic logic [7:0] bcd_inc(input logic [7:0] v, input logic [7:0] last);
    logic [7:0] r;
    if (v == last) begin
      r = 8'h00;
    end else if (v[3:0] == 4'd9) begin
      r = {v[7:4] + 4'd1, 4'd0};
    end else begin
      r = {v[7:4], v[3:0] + 4'd1};
    end
    return r;
  endfunction

  // BCD pair to binary: 10*tens + units (max 59).
  function automatic logic [5:0] bcd_to_bin(input logic [7:0] v);
    logic [5:0] hi6;
    hi6 = {2'b00, v[7:4]};
    return (hi6 << 3) + (hi6 << 1) + {2'b00, v[3:0]};
  endfunction

  // Active-high 7-segment pattern {g,f,e,d,c,b,a}.
  function automatic logic [6:0] seg7(input logic [3:0] d);
    logic [6:0] s;
    case (d)
      4'd0:    s = 7'b0111111;
      4'd1:    s = 7'b0000110;
      4'd2:    s = 7'b1011011;
      4'd3:    s = 7'b1001111;
      4'd4:    s = 7'b1100110;
      4'd5:    s = 7'b1101101;
      4'd6:    s = 7'b1111101;
      4'd7:    s = 7'b0000111;
      4'd8:    s = 7'b1111111;
      4'd9:    s = 7'b1101111;
      default: s = 7'b0000000;
    endcase
    return s;
  endfunction

  // Next-state logic for prescaler and time digits.
  always_comb begin
    tick_s = (pcnt_r == PCNT_MAX);
    // Only a genuine tick out of 59 carries; sec_clr suppresses it.
    sec_carry_s  = tick_s & ~sec_clr & (sec_r == 8'h59);
    hour_carry_s = sec_carry_s & (min_r == 8'h59);

    if (tick_s || sec_clr) begin
      pcnt_next_s = '0;
    end else begin
      pcnt_next_s = pcnt_r + PW'(1);
    end

    if (sec_clr) begin
      sec_next_s = 8'h00;
    end else if (tick_s) begin
      sec_next_s = bcd_inc(sec_r, 8'h59);
    end else begin
      sec_next_s = sec_r;
    end

    // Carry and min_up stack; a wrap caused by min_up never reaches hours.
    if (sec_carry_s) begin
      min_step_s = bcd_inc(min_r, 8'h59);
    end else begin
      min_step_s = min_r;
    end
    if (min_up) begin
      min_next_s = bcd_inc(min_step_s, 8'h59);
    end else begin
      min_next_s = min_step_s;
    end

    if (hour_carry_s) begin
      hour_step_s = bcd_inc(hour_r, 8'h23);
    end else begin
      hour_step_s = hour_r;
    end
    if (hour_up) begin
      hour_next_s = bcd_inc(hour_step_s, 8'h23);
    end else begin
      hour_next_s = hour_step_s;
    end
  end

  // Prescaler, digit registers and the tick flag captured with them.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      pcnt_r <= '0;
      sec_r  <= 8'h00;
      min_r  <= 8'h00;
      hour_r <= 8'h00;
      tick   <= 1'b0;
    end else begin
      pcnt_r <= pcnt_next_s;
      sec_r  <= sec_next_s;
      min_r  <= min_next_s;
      hour_r <= hour_next_s;
      tick   <= tick_s;
    end
  end

  // Registered segment and binary views, one cycle behind the digits.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      hour_hi  <= SEG_ZERO;
      hour_lo  <= SEG_ZERO;
      min_hi   <= SEG_ZERO;
      min_lo   <= SEG_ZERO;
      sec_hi   <= SEG_ZERO;
      sec_lo   <= SEG_ZERO;
      hour_bin <= 5'd0;
      sec_bin  <= 6'd0;
    end else begin
      hour_hi  <= seg7(hour_r[7:4]);
      hour_lo  <= seg7(hour_r[3:0]);
      min_hi   <= seg7(min_r[7:4]);
      min_lo   <= seg7(min_r[3:0]);
      sec_hi   <= seg7(sec_r[7:4]);
      sec_lo   <= seg7(sec_r[3:0]);
      hour_bin <= 5'(bcd_to_bin(hour_r));
      sec_bin  <= bcd_to_bin(sec_r);
    end
  end

endmodule
